dac_channel_regbank: RTL and testbench



---
 rtl/dac_channel_regbank.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_dac_channel_regbank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_channel_regbank.sv
// -----------------------------------------------------------------------------
// dac_channel_regbank
//
// APB register bank for NUM_CH DAC channels. Each channel owns a 256-byte
// window at paddr[11:8] == channel; window 0xF holds the global registers.
// Gain, offset, mux and DDS step are double-buffered: APB writes land in the
// shadow copy and all channels move shadow -> active together, either as soon
// as COMMIT is written (SYNC_MODE=0) or on the next update_sync frame tick
// (SYNC_MODE=1). Filter coefficients for every channel go through one shared
// FIFO that drains over a valid/ready handshake.
//
// Optional feature (compile-time macro DAC_REGBANK_STAT_SNAPSHOT_EN):
//   defined   - CTRL.SNAP latches every channel's statistics into snapshot
//               registers and statistic reads return the snapshot.
//   undefined - SNAP is ignored and statistic reads return the live inputs.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   i_psel .. i_pwdata    APB request (paddr[11:2] decoded)
//   o_prdata, o_pready,
//   o_pslverr             APB response (combinational, zero wait states)
//   i_update_sync         frame tick for synchronous commits
//   o_gain, o_offset,
//   o_mux, o_dds_step     active per-channel values, channel n at [W*n +: W]
//   o_dds_cfg, o_dds_cfg_ce  DDS config and one-cycle per-channel write strobe
//   o_filter_cfg_*        coefficient FIFO head (din, ch, valid) / i_filter_cfg_ready
//   i_stat_min/max/count  live per-channel statistics
// -----------------------------------------------------------------------------
module dac_channel_regbank #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned COEF_DEPTH = 16,
  localparam int unsigned LVL_W     = $clog2(COEF_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_psel,
  input  logic                   i_penable,
  input  logic                   i_pwrite,
  input  logic [31:0]            i_paddr,
  input  logic [31:0]            i_pwdata,
  output logic [31:0]            o_prdata,
  output logic                   o_pready,
  output logic                   o_pslverr,
  input  logic                   i_update_sync,
  output logic [NUM_CH*16-1:0]   o_gain,
  output logic [NUM_CH*16-1:0]   o_offset,
  output logic [NUM_CH*3-1:0]    o_mux,
  output logic [NUM_CH*32-1:0]   o_dds_step,
  output logic [NUM_CH*8-1:0]    o_dds_cfg,
  output logic [NUM_CH-1:0]      o_dds_cfg_ce,
  output logic [24:0]            o_filter_cfg_din,
  output logic [3:0]             o_filter_cfg_ch,
  output logic                   o_filter_cfg_valid,
  input  logic                   i_filter_cfg_ready,
  input  logic [NUM_CH*8-1:0]    i_stat_min,
  input  logic [NUM_CH*8-1:0]    i_stat_max,
  input  logic [NUM_CH*32-1:0]   i_stat_count
);

  localparam int unsigned AW = $clog2(COEF_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_CH*16-1:0] r_gain_sh, r_gain_act;
  logic [NUM_CH*16-1:0] r_offset_sh, r_offset_act;
  logic [NUM_CH*3-1:0]  r_mux_sh, r_mux_act;
  logic [NUM_CH*32-1:0] r_step_sh, r_step_act;
  logic [NUM_CH*8-1:0]  r_dds_cfg;
  logic [NUM_CH-1:0]    r_dds_cfg_ce;
  logic                 r_sync_mode;
  logic                 r_pending;
  logic [1:0]           r_err;

  logic [28:0]          r_mem [COEF_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [LVL_W-1:0]     r_level;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       w_acc, w_wr, w_rd;
  logic [3:0] w_ch;
  logic [7:0] w_off;
  logic       w_is_ch, w_is_glb;
  logic       w_ch_off_ok, w_ch_off_ro;
  logic       w_glb_off_ok;
  logic       w_unmapped, w_ro_err, w_ovf, w_pslverr, w_wr_ok;
  logic       w_unused_addr;

  assign w_acc    = i_psel & i_penable;
  assign w_wr     = w_acc & i_pwrite;
  assign w_rd     = w_acc & ~i_pwrite;
  assign w_ch     = i_paddr[11:8];
  assign w_off    = {i_paddr[7:2], 2'b00};
  assign w_is_ch  = ({28'd0, w_ch} < NUM_CH);
  assign w_is_glb = (w_ch == 4'hF);
  assign w_unused_addr = ^{i_paddr[31:12], i_paddr[1:0]};

  always_comb begin
    w_ch_off_ok = 1'b0;
    w_ch_off_ro = 1'b0;
    case (w_off)
      8'h00, 8'h04, 8'h0C, 8'h14, 8'h18: w_ch_off_ok = 1'b1;
      8'h20, 8'h24, 8'h2C: begin
        w_ch_off_ok = 1'b1;
        w_ch_off_ro = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_glb_off_ok = (w_off == 8'h00) || (w_off == 8'h04) ||
                        (w_off == 8'h08) || (w_off == 8'h0C);

  // ---------------------------------------------------------------------------
  // Coefficient FIFO control
  // ---------------------------------------------------------------------------
  logic        w_valid, w_full, w_pop, w_push, w_coef_req;
  logic [28:0] w_head;

  assign w_valid    = (r_level != '0);
  assign w_full     = (r_level == LVL_W'(COEF_DEPTH));
  assign w_pop      = w_valid & i_filter_cfg_ready;
  assign w_coef_req = w_wr & w_is_glb & (w_off == 8'h08);
  // A pop in the same cycle frees a slot, so a push against a full FIFO is
  // only an overflow when nothing is leaving.
  assign w_ovf      = w_coef_req & w_full & ~w_pop;
  assign w_push     = w_coef_req & ~w_ovf;
  assign w_head     = r_mem[r_rptr];

  // ---------------------------------------------------------------------------
  // Error response
  // ---------------------------------------------------------------------------
  assign w_unmapped = w_acc & ~((w_is_ch & w_ch_off_ok) | (w_is_glb & w_glb_off_ok));
  assign w_ro_err   = w_wr & ((w_is_ch & w_ch_off_ro) | (w_is_glb & (w_off == 8'h04)));
  assign w_pslverr  = w_unmapped | w_ro_err | w_ovf;
  assign w_wr_ok    = w_wr & ~w_pslverr;

  // ---------------------------------------------------------------------------
  // Global control and commit sequencing
  // ---------------------------------------------------------------------------
  logic w_ctrl_wr, w_err_wr, w_commit_req, w_mode_next, w_apply, w_pending_d;

  assign w_ctrl_wr    = w_wr_ok & w_is_glb & (w_off == 8'h00);
  assign w_err_wr     = w_wr_ok & w_is_glb & (w_off == 8'h0C);
  assign w_commit_req = w_ctrl_wr & i_pwdata[0];
  // The CTRL write that carries COMMIT also decides which mode it runs in.
  assign w_mode_next  = w_ctrl_wr ? i_pwdata[1] : r_sync_mode;

  always_comb begin
    w_apply     = 1'b0;
    w_pending_d = r_pending;
    if (w_commit_req) begin
      // update_sync in the COMMIT cycle is deliberately not considered.
      if (w_mode_next) begin
        w_pending_d = 1'b1;
      end else begin
        w_apply     = 1'b1;
        w_pending_d = 1'b0;
      end
    end else if (r_pending && (!w_mode_next || i_update_sync)) begin
      // Either the frame tick arrived or SYNC_MODE was dropped while waiting.
      w_apply     = 1'b1;
      w_pending_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics source (live or snapshot)
  // ---------------------------------------------------------------------------
  logic [NUM_CH*8-1:0]  w_stat_min, w_stat_max;
  logic [NUM_CH*32-1:0] w_stat_count;

`ifdef DAC_REGBANK_STAT_SNAPSHOT_EN
  logic [NUM_CH*8-1:0]  r_snap_min, r_snap_max;
  logic [NUM_CH*32-1:0] r_snap_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_min   <= '0;
      r_snap_max   <= '0;
      r_snap_count <= '0;
    end else if (w_ctrl_wr && i_pwdata[2]) begin
      r_snap_min   <= i_stat_min;
      r_snap_max   <= i_stat_max;
      r_snap_count <= i_stat_count;
    end
  end

  assign w_stat_min   = r_snap_min;
  assign w_stat_max   = r_snap_max;
  assign w_stat_count = r_snap_count;
`else
  assign w_stat_min   = i_stat_min;
  assign w_stat_max   = i_stat_max;
  assign w_stat_count = i_stat_count;
`endif

  // ---------------------------------------------------------------------------
  // Register updates
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gain_sh    <= '0;
      r_gain_act   <= '0;
      r_offset_sh  <= '0;
      r_offset_act <= '0;
      r_mux_sh     <= '0;
      r_mux_act    <= '0;
      r_step_sh    <= '0;
      r_step_act   <= '0;
      r_dds_cfg    <= '0;
      r_dds_cfg_ce <= '0;
      r_sync_mode  <= 1'b0;
      r_pending    <= 1'b0;
      r_err        <= '0;
    end else begin
      r_dds_cfg_ce <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_wr_ok && w_is_ch && (w_ch == 4'(c))) begin
          case (w_off)
            8'h00: r_gain_sh[16*c +: 16]   <= i_pwdata[15:0];
            8'h04: r_offset_sh[16*c +: 16] <= i_pwdata[15:0];
            8'h0C: r_mux_sh[3*c +: 3]      <= i_pwdata[2:0];
            8'h14: begin
              r_dds_cfg[8*c +: 8] <= i_pwdata[7:0];
              r_dds_cfg_ce[c]     <= 1'b1;
            end
            8'h18: r_step_sh[32*c +: 32]   <= i_pwdata;
            default: ;
          endcase
        end
      end
      if (w_apply) begin
        r_gain_act   <= r_gain_sh;
        r_offset_act <= r_offset_sh;
        r_mux_act    <= r_mux_sh;
        r_step_act   <= r_step_sh;
      end
      if (w_ctrl_wr) r_sync_mode <= i_pwdata[1];
      r_pending <= w_pending_d;
      r_err <= (r_err & ~(w_err_wr ? i_pwdata[1:0] : 2'b00)) | {w_ovf, w_unmapped};
    end
  end

  // FIFO storage carries no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_pwdata[31:28], i_pwdata[24:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata, w_status;

  always_comb begin
    w_status                = '0;
    w_status[0]             = r_pending;
    w_status[1]             = w_full;
    w_status[2]             = ~w_valid;
    w_status[8 +: LVL_W]    = r_level;
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ch) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_ch == 4'(c)) begin
          case (w_off)
            8'h00: w_rdata = {16'd0, r_gain_sh[16*c +: 16]};
            8'h04: w_rdata = {16'd0, r_offset_sh[16*c +: 16]};
            8'h0C: w_rdata = {29'd0, r_mux_sh[3*c +: 3]};
            8'h14: w_rdata = {24'd0, r_dds_cfg[8*c +: 8]};
            8'h18: w_rdata = r_step_sh[32*c +: 32];
            8'h20: w_rdata = {24'd0, w_stat_min[8*c +: 8]};
            8'h24: w_rdata = {24'd0, w_stat_max[8*c +: 8]};
            8'h2C: w_rdata = w_stat_count[32*c +: 32];
            default: ;
          endcase
        end
      end
    end else if (w_is_glb) begin
      case (w_off)
        8'h00: w_rdata = {30'd0, r_sync_mode, 1'b0};
        8'h04: w_rdata = w_status;
        8'h0C: w_rdata = {30'd0, r_err};
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_prdata           = (w_rd && !w_pslverr) ? w_rdata : 32'd0;
  assign o_pready           = 1'b1;
  assign o_pslverr          = w_pslverr;
  assign o_gain             = r_gain_act;
  assign o_offset           = r_offset_act;
  assign o_mux              = r_mux_act;
  assign o_dds_step         = r_step_act;
  assign o_dds_cfg          = r_dds_cfg;
  assign o_dds_cfg_ce       = r_dds_cfg_ce;
  assign o_filter_cfg_valid = w_valid;
  assign o_filter_cfg_din   = w_valid ? w_head[24:0]  : 25'd0;
  assign o_filter_cfg_ch    = w_valid ? w_head[28:25] : 4'd0;

endmodule

// File: tb/tb_dac_channel_regbank.sv
module tb_dac_channel_regbank;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned COEF_DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 psel, penable, pwrite;
  logic [31:0]          paddr, pwdata, prdata;
  logic                 pready, pslverr;
  logic                 update_sync;
  logic [NUM_CH*16-1:0] gain, offset;
  logic [NUM_CH*3-1:0]  mux;
  logic [NUM_CH*32-1:0] dds_step;
  logic [NUM_CH*8-1:0]  dds_cfg;
  logic [NUM_CH-1:0]    dds_cfg_ce;
  logic [24:0]          filter_cfg_din;
  logic [3:0]           filter_cfg_ch;
  logic                 filter_cfg_valid, filter_cfg_ready;
  logic [NUM_CH*8-1:0]  stat_min, stat_max;
  logic [NUM_CH*32-1:0] stat_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  dac_channel_regbank #(
    .NUM_CH     (NUM_CH),
    .COEF_DEPTH (COEF_DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_psel             (psel),
    .i_penable          (penable),
    .i_pwrite           (pwrite),
    .i_paddr            (paddr),
    .i_pwdata           (pwdata),
    .o_prdata           (prdata),
    .o_pready           (pready),
    .o_pslverr          (pslverr),
    .i_update_sync      (update_sync),
    .o_gain             (gain),
    .o_offset           (offset),
    .o_mux              (mux),
    .o_dds_step         (dds_step),
    .o_dds_cfg          (dds_cfg),
    .o_dds_cfg_ce       (dds_cfg_ce),
    .o_filter_cfg_din   (filter_cfg_din),
    .o_filter_cfg_ch    (filter_cfg_ch),
    .o_filter_cfg_valid (filter_cfg_valid),
    .i_filter_cfg_ready (filter_cfg_ready),
    .i_stat_min         (stat_min),
    .i_stat_max         (stat_max),
    .i_stat_count       (stat_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Setup phase on one negedge, access phase on the next; the response is
  // sampled mid access phase and the task returns just after the taking edge.
  task automatic apb(input logic [31:0] addr, input logic [31:0] data, input logic wr);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1;
    last_rdata = prdata;
    last_err   = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    apb(addr, data, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr);
    apb(addr, 32'd0, 1'b0);
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    update_sync = 1'b1;
    @(negedge clk);
    update_sync = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; update_sync = 1'b0; filter_cfg_ready = 1'b0;
    stat_min   = {8'hF0, 8'h11};
    stat_max   = {8'h7E, 8'h22};
    stat_count = {32'hBBBB0000, 32'h0000AAAA};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_gain",   gain, 0);
    check("rst_offset", offset, 0);
    check("rst_mux",    mux, 0);
    check("rst_step",   dds_step, 0);
    check("rst_cfg",    dds_cfg, 0);
    check("rst_ce",     dds_cfg_ce, 0);
    check("rst_valid",  filter_cfg_valid, 0);
    check("rst_din",    filter_cfg_din, 0);
    check("pready",     pready, 1);
    rd(32'h000);
    check("rd_gain0", last_rdata, 0);
    check("rd_gain0_err", last_err, 0);
    rd(32'hF04);
    check("status_rst", last_rdata, 32'h4);

    // Immediate commit
    wr(32'h100, 32'h1234);
    rd(32'h100);
    check("shadow_rd", last_rdata, 32'h1234);
    check("active_hold", gain[31:16], 0);
    wr(32'hF00, 32'h1);
    check("commit_now", gain[31:16], 16'h1234);
    check("commit_ch0", gain[15:0], 0);

    // Synchronous commit
    wr(32'hF00, 32'h2);
    wr(32'hF00, 32'h3);
    rd(32'hF04);
    check("pending_set", last_rdata, 32'h5);
    rd(32'hF00);
    check("ctrl_rd", last_rdata, 32'h2);
    wr(32'h004, 32'h55);
    check("pend_hold", offset[15:0], 0);
    pulse_sync();
    check("sync_apply", offset[15:0], 16'h55);
    rd(32'hF04);
    check("pending_clr", last_rdata, 32'h4);
    wr(32'h104, 32'h77);
    pulse_sync();
    check("sync_nopend", offset[31:16], 0);
    // update_sync coincident with the COMMIT write is ignored
    update_sync = 1'b1;
    wr(32'hF00, 32'h3);
    update_sync = 1'b0;
    check("sync_same_cyc", offset[31:16], 0);
    rd(32'hF04);
    check("pending_again", last_rdata, 32'h5);
    pulse_sync();
    check("sync_apply2", offset[31:16], 16'h77);
    // Dropping SYNC_MODE while pending applies at once
    wr(32'h00C, 32'h5);
    wr(32'hF00, 32'h3);
    check("mux_hold", mux[2:0], 0);
    wr(32'hF00, 32'h0);
    check("mode_drop", mux[2:0], 3'h5);
    rd(32'hF04);
    check("mode_drop_st", last_rdata, 32'h4);

    // DDS_CFG direct write and strobe
    wr(32'h014, 32'hA5);
    check("dds_cfg", dds_cfg[7:0], 8'hA5);
    check("ce_pulse", dds_cfg_ce, 2'b01);
    @(posedge clk); #1;
    check("ce_clear", dds_cfg_ce, 2'b00);

    // Coefficient FIFO: fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      wr(32'hF08, 32'h1000_0000 | 32'(i));
      check("push_err", last_err, 0);
    end
    rd(32'hF04);
    check("fifo_full_st", last_rdata, 32'h1002);
    wr(32'hF08, 32'h1000_0063);
    check("ovf_err", last_err, 1);
    rd(32'hF0C);
    check("err_ovf", last_rdata, 32'h2);
    wr(32'hF0C, 32'h2);
    rd(32'hF0C);
    check("err_w1c", last_rdata, 0);
    @(negedge clk);
    filter_cfg_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("beat_valid", filter_cfg_valid, 1);
      check("beat_din", filter_cfg_din, 25'(i));
      check("beat_ch", filter_cfg_ch, 4'h1);
      @(negedge clk);
    end
    #1;
    check("drained", filter_cfg_valid, 0);
    filter_cfg_ready = 1'b0;

    // Push into a full FIFO while it pops: accepted, level unchanged
    for (int i = 0; i < 16; i++) wr(32'hF08, 32'h2000_0100 + 32'(i));
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hF08; pwdata = 32'h2000_0200;
    @(negedge clk);
    penable = 1'b1; filter_cfg_ready = 1'b1;
    #1;
    check("full_pop_err", pslverr, 0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; filter_cfg_ready = 1'b0;
    check("full_pop_head", filter_cfg_din, 25'h101);
    rd(32'hF04);
    check("full_pop_lvl", last_rdata, 32'h1002);
    filter_cfg_ready = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("drained2", filter_cfg_valid, 0);
    filter_cfg_ready = 1'b0;

    // Error cases
    wr(32'h020, 32'h1);
    check("ro_err", last_err, 1);
    rd(32'hF0C);
    check("ro_no_errbit", last_rdata, 0);
    rd(32'h300);
    check("unmap_err", last_err, 1);
    check("unmap_data", last_rdata, 0);
    rd(32'hF0C);
    check("err_unmap", last_rdata, 32'h1);
    wr(32'hF0C, 32'h1);
    rd(32'hF0C);
    check("err_clr", last_rdata, 0);
    rd(32'h008);
    check("undef_off", last_err, 1);
    wr(32'hF0C, 32'h1);

    // Statistics
    wr(32'hF00, 32'h4);
    rd(32'hF00);
    check("snap_rd0", last_rdata, 0);
    rd(32'h02C);
    check("stat_cnt", last_rdata, 32'h0000AAAA);
    rd(32'h120);
    check("stat_min1", last_rdata, 32'hF0);
    rd(32'h124);
    check("stat_max1", last_rdata, 32'h7E);
    stat_count[31:0] = 32'h1234;
    rd(32'h02C);
`ifdef DAC_REGBANK_STAT_SNAPSHOT_EN
    check("stat_snap", last_rdata, 32'h0000AAAA);
`else
    check("stat_live", last_rdata, 32'h1234);
`endif

    // Reset while a commit is pending discards it
    wr(32'h018, 32'hDEADBEEF);
    wr(32'hF00, 32'h2);
    wr(32'hF00, 32'h3);
    check("step_hold", dds_step[31:0], 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_sync();
    check("rst_pend_step", dds_step[31:0], 0);
    rd(32'hF04);
    check("rst_pend_st", last_rdata, 32'h4);
    rd(32'h018);
    check("rst_shadow", last_rdata, 0);
    rd(32'hF00);
    check("rst_mode", last_rdata, 0);
    check("rst_cfg2", dds_cfg, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
